rr_encoder_arbiter: RTL and testbench
=====================================

// Module: rr_encoder_arbiter
// PURPOSE
//  Round-robin arbiter that shares one downstream resource among N_REQ requesters.
//  Outputs a one-hot grant and its binary-encoded index (4-to-2 encoder form for N_REQ=4).
//  Sits in front of the encoder datapath, which sees a stable one-hot word for a whole tenure.
//  A hold limit keeps any one requester from starving the others.
// PARAMETERS
//  N_REQ     4   number of requesters (>=2)
//  IDX_W     2   width of gnt_idx; must satisfy 2**IDX_W >= N_REQ
//  HOLD_MAX  8   max cycles a grant may be held (>=1)
//  CNT_W     4   hold counter width; must satisfy 2**CNT_W > HOLD_MAX
// PORTS
//  clk        in   1      rising-edge clock
//  rst_n      in   1      asynchronous active-low reset
//  req        in   N_REQ  level request; req[i] high = requester i wants resource
//  gnt        out  N_REQ  registered one-hot grant; all-zero when no owner
//  gnt_idx    out  IDX_W  binary index of gnt owner; 0 when gnt_valid=0
//  gnt_valid  out  1      high while a grant is held (== |gnt)
//  timeout    out  1      1-cycle pulse: current grant force-released at HOLD_MAX
// BEHAVIOUR
//  Reset (async, rst_n=0):
//   - gnt=0, gnt_idx=0, gnt_valid=0, timeout=0, state=IDLE, hold_cnt=0
//   - last=N_REQ-1, so req[0] has first priority
//   - Reset asserted mid-grant clears all outputs immediately, with no timeout pulse.
//  FSM states: IDLE, GRANT. All outputs are registered.
//  IDLE:
//   - If req==0, stay in IDLE.
//   - Else pick the first set bit scanning last+1, last+2, ... modulo N_REQ.
//   - Next cycle: gnt=onehot(winner), gnt_idx=winner, gnt_valid=1, hold_cnt=1, go to GRANT.
//   - Arbitration latency is 1 cycle from req sampled to gnt visible.
//  GRANT (owner o, sampled each edge):
//   - req[o]==0: release. Next cycle gnt=0, gnt_valid=0, gnt_idx=0, last=o, go to IDLE.
//   - req[o]==1 and hold_cnt==HOLD_MAX: force release as above, plus timeout=1 for 1 cycle.
//   - Otherwise: hold_cnt+1; gnt and gnt_idx unchanged.
//   - Changes to other req bits during GRANT are ignored until IDLE.
//  Rules:
//   - Release and timeout in the same cycle: release wins, timeout stays 0.
//   - Every tenure is followed by at least 1 IDLE cycle (gnt_valid low >=1 cycle).
//   - A tenure lasts 1..HOLD_MAX cycles.
//   - The released owner always drops to lowest priority.
//   - Pointer wraps: after o=N_REQ-1, the scan starts at 0.
//   - gnt is always one-hot or zero. gnt_idx always equals encode(gnt).
//   - A lone requester holding req high gets HOLD_MAX cycles on, 1 off, repeated.
//     timeout pulses on every forced release.
// TESTING
//  1 Reset, then req=4'b1111 held -> grant order idx 0,1,2,3,0.
//    Each tenure HOLD_MAX=8 cycles; timeout pulses 4 times; 1 idle cycle between tenures.
//  2 req=4'b0100 for 3 cycles then 0 -> gnt=4'b0100, gnt_idx=2 for 3 cycles.
//    Then gnt=0 with no timeout.
//  3 Owner 1 releases while req=4'b1010 -> next grant goes to idx 3, not 1 (rotation).
//    After 3 releases, the next grant goes to idx 1 (wrap-around).
//  4 req[0] drops exactly at hold_cnt==8 -> release taken, timeout stays 0.
//  5 rst_n pulsed low mid-tenure (gnt=4'b1000) -> all outputs 0 asynchronously.
//    With req=4'b1001 after reset, the first grant goes to idx 0.
//  6 Every cycle: check onehot0(gnt), gnt_valid==|gnt, gnt_idx==encode(gnt), tenure<=HOLD_MAX.

Source files
------------

// File: rtl/rr_encoder_arbiter.sv
// Round-robin arbiter with a bounded hold time, producing a registered one-hot
// grant plus its binary index for the downstream encoder datapath.
module rr_encoder_arbiter #(
    parameter int N_REQ    = 4,
    parameter int IDX_W    = 2,
    parameter int HOLD_MAX = 8,
    parameter int CNT_W    = 4
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic [N_REQ-1:0] req,
    output logic [N_REQ-1:0] gnt,
    output logic [IDX_W-1:0] gnt_idx,
    output logic             gnt_valid,
    output logic             timeout
);

    // state | meaning
    // IDLE  | no owner; arbitrate among req starting after last
    // GRANT | owner gnt_idx holds the resource, hold_cnt counts its cycles
    typedef enum logic {IDLE, GRANT} state_t;

    state_t           state, state_nxt;
    logic [CNT_W-1:0] hold_cnt, cnt_nxt;
    logic [IDX_W-1:0] last, last_nxt;
    logic [N_REQ-1:0] gnt_nxt;
    logic [IDX_W-1:0] idx_nxt;
    logic             valid_nxt;
    logic             timeout_nxt;
    logic [IDX_W-1:0] win;
    logic             win_found;
    int               pos;

    // Scan last+1, last+2, ... so the previous owner is considered last.
    always_comb begin
        win       = '0;
        win_found = 1'b0;
        pos       = 0;
        for (int k = 1; k <= N_REQ; k++) begin
            pos = (int'(last) + k) % N_REQ;
            if (!win_found && req[pos]) begin
                win       = IDX_W'(pos);
                win_found = 1'b1;
            end
        end
    end

    always_comb begin
        state_nxt   = state;
        gnt_nxt     = gnt;
        idx_nxt     = gnt_idx;
        valid_nxt   = gnt_valid;
        timeout_nxt = 1'b0;
        cnt_nxt     = hold_cnt;
        last_nxt    = last;
        case (state)
            IDLE: begin
                if (win_found) begin
                    gnt_nxt      = '0;
                    gnt_nxt[win] = 1'b1;
                    idx_nxt      = win;
                    valid_nxt    = 1'b1;
                    cnt_nxt      = CNT_W'(1);
                    state_nxt    = GRANT;
                end
            end
            GRANT: begin
                // A voluntary release takes precedence over the hold limit.
                if (!req[gnt_idx] || (hold_cnt == CNT_W'(HOLD_MAX))) begin
                    timeout_nxt = req[gnt_idx];
                    gnt_nxt     = '0;
                    idx_nxt     = '0;
                    valid_nxt   = 1'b0;
                    cnt_nxt     = '0;
                    last_nxt    = gnt_idx;
                    state_nxt   = IDLE;
                end else begin
                    cnt_nxt = hold_cnt + CNT_W'(1);
                end
            end
            default: state_nxt = IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state     <= IDLE;
            gnt       <= '0;
            gnt_idx   <= '0;
            gnt_valid <= 1'b0;
            timeout   <= 1'b0;
            hold_cnt  <= '0;
            last      <= IDX_W'(N_REQ - 1);
        end else begin
            state     <= state_nxt;
            gnt       <= gnt_nxt;
            gnt_idx   <= idx_nxt;
            gnt_valid <= valid_nxt;
            timeout   <= timeout_nxt;
            hold_cnt  <= cnt_nxt;
            last      <= last_nxt;
        end
    end

endmodule

// File: tb/tb_rr_encoder_arbiter.sv
// Bench for rr_encoder_arbiter: directed scenarios plus randomized requests,
// checked every cycle against a behavioural owner/pointer model.
module tb_rr_encoder_arbiter;
    localparam int N_REQ    = 4;
    localparam int IDX_W    = 2;
    localparam int HOLD_MAX = 8;
    localparam int CNT_W    = 4;

    logic             clk;
    logic             rst_n;
    logic [N_REQ-1:0] req;
    logic [N_REQ-1:0] gnt;
    logic [IDX_W-1:0] gnt_idx;
    logic             gnt_valid;
    logic             timeout;

    int n_checks = 0;
    int n_fail   = 0;

    int m_owner = -1;
    int m_held  = 0;
    int m_last  = N_REQ - 1;
    bit m_to    = 0;

    int grants[$];
    int tenures[$];
    int to_count = 0;
    int run      = 0;
    bit prev_valid = 0;

    rr_encoder_arbiter #(
        .N_REQ(N_REQ), .IDX_W(IDX_W), .HOLD_MAX(HOLD_MAX), .CNT_W(CNT_W)
    ) dut (
        .clk(clk), .rst_n(rst_n), .req(req), .gnt(gnt),
        .gnt_idx(gnt_idx), .gnt_valid(gnt_valid), .timeout(timeout)
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    task automatic chk(input string name, input int act, input int exp);
        n_checks++;
        if (act != exp) begin
            n_fail++;
            $display("FAIL %s: got %0d expected %0d", name, act, exp);
        end
    endtask

    function automatic int encode(input logic [N_REQ-1:0] v);
        int r = 0;
        for (int i = 0; i < N_REQ; i++) if (v[i]) r = i;
        return r;
    endfunction

    // Next-cycle owner from the arbitration rules, using the req about to be sampled.
    task automatic model_step();
        m_to = 0;
        if (m_owner < 0) begin
            for (int k = 1; k <= N_REQ; k++) begin
                int p;
                p = (m_last + k) % N_REQ;
                if (req[p]) begin
                    m_owner = p;
                    m_held  = 1;
                    break;
                end
            end
        end else if (!req[m_owner]) begin
            m_last  = m_owner;
            m_owner = -1;
            m_held  = 0;
        end else if (m_held == HOLD_MAX) begin
            m_last  = m_owner;
            m_owner = -1;
            m_held  = 0;
            m_to    = 1;
        end else begin
            m_held++;
        end
    endtask

    initial begin
        forever begin
            @(negedge clk);
            if (!rst_n) begin
                m_owner = -1;
                m_held  = 0;
                m_last  = N_REQ - 1;
                m_to    = 0;
            end
            chk("gnt", int'(gnt), (m_owner < 0) ? 0 : (1 << m_owner));
            chk("gnt_idx", int'(gnt_idx), (m_owner < 0) ? 0 : m_owner);
            chk("gnt_valid", int'(gnt_valid), (m_owner >= 0) ? 1 : 0);
            chk("timeout", int'(timeout), int'(m_to));
            chk("onehot0", ($countones(gnt) <= 1) ? 1 : 0, 1);
            chk("valid_eq_or", int'(gnt_valid), int'(|gnt));
            chk("idx_encode", int'(gnt_idx), encode(gnt));
            if (gnt_valid && !prev_valid) grants.push_back(int'(gnt_idx));
            if (timeout) to_count++;
            if (gnt_valid) run++;
            else begin
                if (run > 0) tenures.push_back(run);
                run = 0;
            end
            chk("tenure_le_max", (run <= HOLD_MAX) ? 1 : 0, 1);
            prev_valid = gnt_valid;
            if (rst_n) model_step();
        end
    end

    task automatic tick(input int n);
        repeat (n) @(posedge clk);
        #1;
    endtask

    task automatic clear_rec();
        grants.delete();
        tenures.delete();
        to_count = 0;
    endtask

    function automatic int q_at(input int q[$], input int i);
        return (i < q.size()) ? q[i] : -1;
    endfunction

    initial begin
        int e1[5] = '{0, 1, 2, 3, 0};
        int e3[3] = '{1, 3, 1};
        rst_n = 1'b1;
        req   = '0;
        #1 rst_n = 1'b0;
        tick(2);
        rst_n = 1'b1;
        chk("reset_gnt", int'(gnt), 0);
        chk("reset_valid", int'(gnt_valid), 0);
        chk("reset_idx", int'(gnt_idx), 0);
        chk("reset_timeout", int'(timeout), 0);

        // 1: all requesting, full-length tenures in rotation
        clear_rec();
        req = 4'b1111;
        tick(40);
        req = 4'b0000;
        tick(3);
        chk("t1_ngrants", grants.size(), 5);
        for (int i = 0; i < 5; i++) chk("t1_order", q_at(grants, i), e1[i]);
        for (int i = 0; i < 4; i++) chk("t1_tenure", q_at(tenures, i), HOLD_MAX);
        chk("t1_timeouts", to_count, 4);

        // 2: short voluntary tenure
        clear_rec();
        req = 4'b0100;
        tick(3);
        req = 4'b0000;
        tick(3);
        chk("t2_grant", q_at(grants, 0), 2);
        chk("t2_tenure", q_at(tenures, 0), 3);
        chk("t2_timeouts", to_count, 0);

        // 3: rotation past the released owner, then wrap-around
        clear_rec();
        req = 4'b0010;
        tick(2);
        req = 4'b1010;
        tick(25);
        req = 4'b0000;
        tick(3);
        chk("t3_ngrants", grants.size(), 3);
        for (int i = 0; i < 3; i++) chk("t3_order", q_at(grants, i), e3[i]);

        // 4: release coincides with the hold limit
        clear_rec();
        req = 4'b0001;
        tick(8);
        req = 4'b0000;
        tick(3);
        chk("t4_tenure", q_at(tenures, 0), HOLD_MAX);
        chk("t4_timeouts", to_count, 0);

        // 5: async reset mid-tenure
        req = 4'b1000;
        tick(3);
        chk("t5_pre_gnt", int'(gnt), 8);
        #2 rst_n = 1'b0;
        #1;
        chk("t5_async_gnt", int'(gnt), 0);
        chk("t5_async_valid", int'(gnt_valid), 0);
        chk("t5_async_idx", int'(gnt_idx), 0);
        chk("t5_async_timeout", int'(timeout), 0);
        @(posedge clk);
        #1;
        rst_n = 1'b1;
        req   = 4'b1001;
        tick(2);
        chk("t5_first_gnt", int'(gnt), 1);
        chk("t5_first_idx", int'(gnt_idx), 0);
        req = 4'b0000;
        tick(2);

        // Randomized requests with occasional resets
        for (int c = 0; c < 600; c++) begin
            if ($urandom_range(0, 9) == 0) req = 4'($urandom_range(0, 15));
            if ($urandom_range(0, 149) == 0) begin
                rst_n = 1'b0;
                tick(1);
                rst_n = 1'b1;
            end else begin
                tick(1);
            end
        end
        req = 4'b0000;
        tick(3);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
